// File: rtl/sprite_renderer.sv
// ============================================================================
// Module      : sprite_renderer
// Description : Per-pixel sprite fetch. Forms the sprite ROM address from the
//               scan position, sequences animation frames and converts RGB565
//               to RRRGGGBB with colour-key transparency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_renderer #(
    parameter int          SPRITE_W    = 64,
    parameter int          SPRITE_H    = 64,
    parameter int          FRAMES      = 4,
    parameter int          FRAME_TICKS = 8,
    parameter int          ADDR_W      = 14,
    parameter logic [15:0] TRANSPARENT = 16'hF81F,
    parameter logic [7:0]  BG_COLOR    = 8'h00,
    localparam int         c_FRAME_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic [9:0]           posx,
    input  logic [9:0]           posy,
    input  logic [3:0]           state,
    input  logic                 facing_left,
    input  logic                 frame_tick,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [15:0]          rom_data,
    output logic [7:0]           color_out,
    output logic [c_FRAME_W-1:0] anim_frame,
    output logic                 anim_done
);

    localparam int c_LX_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int c_LY_W   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int c_TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [ADDR_W-1:0]    c_FRAME_SIZE = ADDR_W'(SPRITE_W * SPRITE_H);
    localparam logic [ADDR_W-1:0]    c_ROW_SIZE   = ADDR_W'(SPRITE_W);
    localparam logic [c_FRAME_W-1:0] c_LAST_FRAME = c_FRAME_W'(FRAMES - 1);
    localparam logic [c_TICK_W-1:0]  c_LAST_TICK  = c_TICK_W'(FRAME_TICKS - 1);
    localparam logic [c_FRAME_W-1:0] c_FRAME_ONE  = c_FRAME_W'(1);
    localparam logic [c_TICK_W-1:0]  c_TICK_ONE   = c_TICK_W'(1);

    logic [ADDR_W-1:0]    r_rom_addr;
    logic                 r_inside_d1;
    logic                 r_inside_d2;
    logic [7:0]           r_color;
    logic [c_FRAME_W-1:0] r_anim_frame;
    logic [c_TICK_W-1:0]  r_tick;
    logic                 r_anim_done;
    logic [3:0]           r_prev_state;

    logic [10:0]          w_x_end;
    logic [10:0]          w_y_end;
    logic                 w_inside;
    logic [c_LX_W-1:0]    w_lx;
    logic [c_LY_W-1:0]    w_ly;
    logic [c_LX_W-1:0]    w_col;
    logic [ADDR_W-1:0]    w_addr;
    logic                 w_loop_state;
    logic                 w_oneshot_state;
    logic                 w_tick_wrap;

    // 11-bit window ends so a sprite near the right/bottom edge never wraps
    assign w_x_end  = {1'b0, posx} + 11'(SPRITE_W);
    assign w_y_end  = {1'b0, posy} + 11'(SPRITE_H);
    assign w_inside = (pixel_x >= posx) && ({1'b0, pixel_x} < w_x_end) &&
                      (pixel_y >= posy) && ({1'b0, pixel_y} < w_y_end);

    assign w_lx  = c_LX_W'(pixel_x - posx);
    assign w_ly  = c_LY_W'(pixel_y - posy);
    // SPRITE_W is a power of two, so SPRITE_W-1-lx is a bitwise inversion
    assign w_col = facing_left ? ~w_lx : w_lx;

    assign w_addr = ADDR_W'(r_anim_frame) * c_FRAME_SIZE +
                    ADDR_W'(w_ly) * c_ROW_SIZE + ADDR_W'(w_col);

    // Fetch pipeline: address, ROM read, colour conversion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr  <= '0;
            r_inside_d1 <= 1'b0;
            r_inside_d2 <= 1'b0;
            r_color     <= BG_COLOR;
        end else begin
            r_rom_addr  <= w_inside ? w_addr : '0;
            r_inside_d1 <= w_inside;
            r_inside_d2 <= r_inside_d1;
            if (!r_inside_d2 || (rom_data == TRANSPARENT)) begin
                r_color <= BG_COLOR;
            end else begin
                r_color <= {rom_data[15:13], rom_data[10:8], rom_data[4:3]};
            end
        end
    end

    assign w_loop_state    = (state < 4'd3);
    assign w_oneshot_state = (state >= 4'd3) && (state <= 4'd5);
    assign w_tick_wrap     = (r_tick == c_LAST_TICK);

    // Animation sequencer; a state change outranks a coincident frame_tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_anim_frame <= '0;
            r_tick       <= '0;
            r_anim_done  <= 1'b0;
            r_prev_state <= '0;
        end else begin
            r_prev_state <= state;
            if (state != r_prev_state) begin
                r_anim_frame <= '0;
                r_tick       <= '0;
                r_anim_done  <= 1'b0;
            end else if (!(w_loop_state || w_oneshot_state)) begin
                r_anim_frame <= '0;
                r_tick       <= '0;
                r_anim_done  <= 1'b0;
            end else if (frame_tick) begin
                r_tick <= w_tick_wrap ? '0 : r_tick + c_TICK_ONE;
                if (w_tick_wrap) begin
                    if (w_loop_state) begin
                        r_anim_frame <= (r_anim_frame == c_LAST_FRAME) ? '0 :
                                        r_anim_frame + c_FRAME_ONE;
                    end else if (r_anim_frame != c_LAST_FRAME) begin
                        r_anim_frame <= r_anim_frame + c_FRAME_ONE;
                        r_anim_done  <= (r_anim_frame + c_FRAME_ONE) == c_LAST_FRAME;
                    end
                end
            end
        end
    end

    assign rom_addr   = r_rom_addr;
    assign color_out  = r_color;
    assign anim_frame = r_anim_frame;
    assign anim_done  = r_anim_done;

endmodule

`default_nettype wire

// File: tb/tb_sprite_renderer.sv
// ============================================================================
// Module      : tb_sprite_renderer
// Description : Directed self-checking bench for sprite_renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_renderer;

    logic        clk;
    logic        rst;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [9:0]  posx;
    logic [9:0]  posy;
    logic [3:0]  state;
    logic        facing_left;
    logic        frame_tick;
    logic [13:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] rom_word;
    logic [7:0]  color_out;
    logic [1:0]  anim_frame;
    logic        anim_done;

    int n_checks;
    int n_errors;

    sprite_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .posx        (posx),
        .posy        (posy),
        .state       (state),
        .facing_left (facing_left),
        .frame_tick  (frame_tick),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .color_out   (color_out),
        .anim_frame  (anim_frame),
        .anim_done   (anim_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency; content set by the bench
    always @(posedge clk) rom_data <= rom_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic addr_at(input string tag, input int x, input int y, input int exp);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        step();
        chk(tag, 32'(rom_addr), 32'(exp));
    endtask

    task automatic color_at(input string tag, input int x, input int y, input int exp);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        step();
        step();
        step();
        chk(tag, 32'(color_out), 32'(exp));
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        pixel_x     = '0;
        pixel_y     = '0;
        posx        = 10'd100;
        posy        = 10'd50;
        state       = 4'd0;
        facing_left = 1'b0;
        frame_tick  = 1'b0;
        rom_word    = 16'hFFFF;

        step();
        chk("rst_addr",  32'(rom_addr),   32'h0);
        chk("rst_color", 32'(color_out),  32'h0);
        chk("rst_frame", 32'(anim_frame), 32'h0);
        chk("rst_done",  32'(anim_done),  32'h0);
        rst = 1'b0;

        // Addressing, unmirrored, frame 0
        addr_at("addr_origin",   100,  50,    0);
        addr_at("addr_right",    163,  50,   63);
        addr_at("addr_row1",     100,  51,   64);
        addr_at("addr_out_x",    164,  50,    0);
        addr_at("addr_bottom",   100, 113, 4032);
        addr_at("addr_out_y",    100, 114,    0);
        addr_at("addr_out_left",  99,  50,    0);

        // Sprite near x=1023: window end must not wrap
        posx = 10'd1000;
        addr_at("addr_edge_nowrap", 1010, 50, 10);
        posx = 10'd100;

        // Mirrored
        facing_left = 1'b1;
        addr_at("mir_origin", 100, 50, 63);
        addr_at("mir_163_52", 163, 52, 128);
        facing_left = 1'b0;

        // Colour and exact latency
        rom_word = 16'hFFFF;
        color_at("col_outside_ff", 0, 0, 8'h00);
        pixel_x = 10'd110;
        pixel_y = 10'd60;
        step();
        pixel_x = 10'd0;
        pixel_y = 10'd0;
        step();
        chk("lat_t2_bg", 32'(color_out), 32'h00);
        step();
        chk("lat_t3_ff", 32'(color_out), 32'hFF);
        step();
        chk("lat_t4_bg", 32'(color_out), 32'h00);
        rom_word = 16'hF81F;
        color_at("col_transparent", 110, 60, 8'h00);
        rom_word = 16'hA5C3;
        color_at("col_convert", 110, 60, 8'hB4);
        rom_word = 16'hFFFF;

        // Looping animation (state 0)
        ticks(7);
        chk("loop_7_ticks", 32'(anim_frame), 32'd0);
        ticks(1);
        chk("loop_8_ticks", 32'(anim_frame), 32'd1);
        addr_at("loop_addr_f1", 100, 50, 4096);
        ticks(24);
        chk("loop_32_frame", 32'(anim_frame), 32'd0);
        chk("loop_32_done",  32'(anim_done),  32'd0);

        // One-shot animation (state 3)
        state = 4'd3;
        step();
        ticks(23);
        chk("shot_23_frame", 32'(anim_frame), 32'd2);
        chk("shot_23_done",  32'(anim_done),  32'd0);
        ticks(1);
        chk("shot_24_frame", 32'(anim_frame), 32'd3);
        chk("shot_24_done",  32'(anim_done),  32'd1);
        addr_at("shot_addr_f3", 100, 50, 12288);
        ticks(10);
        chk("shot_sat_frame", 32'(anim_frame), 32'd3);
        chk("shot_sat_done",  32'(anim_done),  32'd1);
        state = 4'd0;
        ticks(1);
        chk("chg_frame", 32'(anim_frame), 32'd0);
        chk("chg_done",  32'(anim_done),  32'd0);
        ticks(7);
        chk("chg_tick_cleared", 32'(anim_frame), 32'd0);
        ticks(1);
        chk("chg_tick_next", 32'(anim_frame), 32'd1);

        // Unlisted state holds frame 0
        state = 4'd7;
        ticks(8);
        chk("bad_state_frame", 32'(anim_frame), 32'd0);
        chk("bad_state_done",  32'(anim_done),  32'd0);

        // Asynchronous reset mid-stream
        state = 4'd3;
        step();
        ticks(13);
        pixel_x = 10'd110;
        pixel_y = 10'd60;
        step();
        step();
        step();
        chk("pre_rst_color", 32'(color_out),  32'hFF);
        chk("pre_rst_frame", 32'(anim_frame), 32'd1);
        chk("pre_rst_addr",  32'(rom_addr),   32'd4746);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_addr",  32'(rom_addr),   32'h0);
        chk("async_rst_color", 32'(color_out),  32'h0);
        chk("async_rst_frame", 32'(anim_frame), 32'h0);
        chk("async_rst_done",  32'(anim_done),  32'h0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("post_rst_t2", 32'(color_out), 32'h00);
        step();
        chk("post_rst_t3", 32'(color_out), 32'hFF);
        chk("post_rst_frame", 32'(anim_frame), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
